// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : RV32I MEM stage - data-memory handshake, load align/extend, MEM/WB reg
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_UIMM = 2'd1,
    WB_BR   = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic    reg_write;
    wb_sel_e wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid_s;
    mem_ctrl_t   mem_ctrl_s;
    wb_ctrl_t    wb_ctrl_s;
    logic [31:0] alu_out;
    logic [31:0] u_imm;
    logic        br_en;
    logic [31:0] rs2_v;
    logic [4:0]  rd;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid_s;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_v;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mem_wb_stage_reg_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  ex_mem_stage_reg_t ex_mem_reg,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              mem_stall,
  output logic              mem_err,
  output mem_wb_stage_reg_t mem_wb_reg
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
  localparam bit               TO_EN  = (MAX_WAIT != 0);

  state_e            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        rmask_q;
  logic [3:0]        wmask_q;
  mem_wb_stage_reg_t mem_wb_q;

  logic              mem_op;
  logic              issue;
  logic              timeout;
  logic [1:0]        off;
  logic [4:0]        lane_sh;
  logic [3:0]        mask_c;
  logic [31:0]       addr_c;
  logic [31:0]       wdata_c;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;
  mem_wb_stage_reg_t wb_pass;
  mem_wb_stage_reg_t wb_done;

  assign mem_op  = ex_mem_reg.valid_s &
                   (ex_mem_reg.mem_ctrl_s.mem_read | ex_mem_reg.mem_ctrl_s.mem_write);
  // Reset gates the combinational request so nothing leaks out while rst is low.
  assign issue   = rst & (state_q == S_IDLE) & mem_op;
  assign timeout = TO_EN & (wait_cnt_q == TO_CNT);

  assign off     = ex_mem_reg.alu_out[1:0];
  assign lane_sh = {off, 3'b000};
  assign addr_c  = {ex_mem_reg.alu_out[31:2], 2'b00};
  assign wdata_c = ex_mem_reg.rs2_v << lane_sh;

  always_comb begin
    mask_c = 4'b0000;
    case (ex_mem_reg.mem_ctrl_s.funct3[1:0])
      2'b00:   mask_c = 4'b0001 << off;
      2'b01:   mask_c = 4'b0011 << off;
      default: mask_c = 4'b1111;
    endcase
  end

  // EX/MEM is held during WAIT, so funct3 and the byte offset are still valid here.
  assign shifted = dmem_rdata >> lane_sh;

  always_comb begin
    load_ext = shifted;
    case (ex_mem_reg.mem_ctrl_s.funct3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_ext = {24'b0, shifted[7:0]};
      F3_HU:   load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    wb_pass         = '0;
    wb_pass.inst    = ex_mem_reg.inst;
    wb_pass.pc      = ex_mem_reg.pc;
    wb_pass.order   = ex_mem_reg.order;
    wb_pass.valid_s = ex_mem_reg.valid_s;
    wb_pass.rd      = ex_mem_reg.rd;
    wb_pass.rd_we   = ex_mem_reg.wb_ctrl_s.reg_write;
    case (ex_mem_reg.wb_ctrl_s.wb_sel)
      WB_UIMM: wb_pass.rd_v = ex_mem_reg.u_imm;
      WB_BR:   wb_pass.rd_v = {31'b0, ex_mem_reg.br_en};
      default: wb_pass.rd_v = ex_mem_reg.alu_out;
    endcase

    wb_done           = wb_pass;
    wb_done.valid_s   = 1'b1;
    wb_done.rd_we     = ex_mem_reg.wb_ctrl_s.reg_write & ~ex_mem_reg.mem_ctrl_s.mem_write;
    wb_done.rd_v      = ex_mem_reg.mem_ctrl_s.mem_write ? 32'b0 : load_ext;
    wb_done.mem_addr  = addr_q;
    wb_done.mem_rmask = rmask_q;
    wb_done.mem_wmask = wmask_q;
    wb_done.mem_rdata = (rmask_q != 4'b0000) ? dmem_rdata : 32'b0;
    wb_done.mem_wdata = (wmask_q != 4'b0000) ? wdata_q : 32'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      mem_wb_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
            addr_q     <= addr_c;
            wdata_q    <= wdata_c;
            rmask_q    <= ex_mem_reg.mem_ctrl_s.mem_read  ? mask_c : 4'b0000;
            wmask_q    <= ex_mem_reg.mem_ctrl_s.mem_write ? mask_c : 4'b0000;
            mem_wb_q   <= '0;
          end else begin
            mem_wb_q   <= wb_pass;
          end
        end
        S_WAIT: begin
          if (dmem_resp) begin
            state_q  <= S_IDLE;
            mem_wb_q <= wb_done;
          end else if (timeout) begin
            state_q  <= S_IDLE;
            mem_wb_q <= '0;
          end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_addr  = (state_q == S_WAIT) ? addr_q  : addr_c;
  assign dmem_wdata = (state_q == S_WAIT) ? wdata_q : wdata_c;
  assign dmem_rmask = (issue & ex_mem_reg.mem_ctrl_s.mem_read)  ? mask_c : 4'b0000;
  assign dmem_wmask = (issue & ex_mem_reg.mem_ctrl_s.mem_write) ? mask_c : 4'b0000;

  // Stall releases in the resp or timeout cycle so EX/MEM advances on that edge.
  assign mem_stall  = issue | (rst & (state_q == S_WAIT) & ~dmem_resp & ~timeout);
  assign mem_err    = rst & (state_q == S_WAIT) & ~dmem_resp & timeout;
  assign mem_wb_reg = mem_wb_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage (MAX_WAIT=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] rd_v;
  } exp_t;

  logic              clk;
  logic              rst;
  ex_mem_stage_reg_t ex_mem_reg;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              mem_stall;
  logic              mem_err;
  mem_wb_stage_reg_t mem_wb_reg;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  mem_stage #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_mem_reg (ex_mem_reg),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err),
    .mem_wb_reg (mem_wb_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ex_mem_stage_reg_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                                           input wb_sel_e ws, input logic rw, input logic [31:0] alu,
                                           input logic [31:0] uimm, input logic br,
                                           input logic [31:0] rs2, input logic [4:0] rd);
    ex_mem_stage_reg_t e;
    e                      = '0;
    e.inst                 = 32'h0000_0013;
    e.pc                   = 32'h0000_1000;
    e.valid_s              = 1'b1;
    e.mem_ctrl_s.mem_read  = mr;
    e.mem_ctrl_s.mem_write = mw;
    e.mem_ctrl_s.funct3    = f3;
    e.wb_ctrl_s.reg_write  = rw;
    e.wb_ctrl_s.wb_sel     = ws;
    e.alu_out              = alu;
    e.u_imm                = uimm;
    e.br_en                = br;
    e.rs2_v                = rs2;
    e.rd                   = rd;
    return e;
  endfunction

  function automatic exp_t ex(input logic [4:0] rd, input logic we, input logic [31:0] v);
    exp_t e;
    e.rd   = rd;
    e.we   = we;
    e.rd_v = v;
    return e;
  endfunction

  // Scoreboard: every valid MEM/WB output must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (mem_wb_reg.valid_s === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got valid rd=%0d rd_v=%h, expected no output",
                 mem_wb_reg.rd, mem_wb_reg.rd_v);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_wb_reg.rd !== mon_e.rd || mem_wb_reg.rd_we !== mon_e.we ||
            mem_wb_reg.rd_v !== mon_e.rd_v) begin
          n_fail++;
          $display("FAIL wb_data: got rd=%0d we=%b rd_v=%h, expected rd=%0d we=%b rd_v=%h",
                   mem_wb_reg.rd, mem_wb_reg.rd_we, mem_wb_reg.rd_v,
                   mon_e.rd, mon_e.we, mon_e.rd_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (mem_wb_reg !== '0) begin
      n_fail++;
      $display("FAIL reset_wb: got %h, expected 0", mem_wb_reg);
    end
    n_tests++;
    if ({dmem_rmask, dmem_wmask, mem_stall, mem_err} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got rmask=%b wmask=%b stall=%b err=%b, expected all 0",
               dmem_rmask, dmem_wmask, mem_stall, mem_err);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_alu();
    step();
    ex_mem_reg = mk(1'b0, 1'b0, 3'b000, WB_ALU, 1'b1, 32'h5, 32'h0, 1'b0, 32'h0, 5'd3);
    exp_q.push_back(ex(5'd3, 1'b1, 32'h5));
    @(negedge clk);
    n_tests++;
    if ({mem_stall, dmem_rmask, dmem_wmask} !== 9'b0) begin
      n_fail++;
      $display("FAIL alu_no_mem: got stall=%b rmask=%b wmask=%b, expected 0", mem_stall, dmem_rmask, dmem_wmask);
    end
    step();
    ex_mem_reg = mk(1'b0, 1'b0, 3'b000, WB_UIMM, 1'b1, 32'h77, 32'hABCD_E000, 1'b0, 32'h0, 5'd4);
    exp_q.push_back(ex(5'd4, 1'b1, 32'hABCD_E000));
    step();
    ex_mem_reg = mk(1'b0, 1'b0, 3'b011, WB_BR, 1'b1, 32'h99, 32'h0, 1'b1, 32'h0, 5'd8);
    exp_q.push_back(ex(5'd8, 1'b1, 32'h1));
    @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_stall: got %b, expected 0", mem_stall);
    end
    step();
    ex_mem_reg = '0;
    step();
  endtask

  task automatic test_lb();
    step();
    ex_mem_reg = mk(1'b1, 1'b0, F3_B, WB_ALU, 1'b1, 32'h1002, 32'h0, 1'b0, 32'h0, 5'd5);
    exp_q.push_back(ex(5'd5, 1'b1, 32'hFFFF_FFFF));
    @(negedge clk);
    n_tests++;
    if (dmem_rmask !== 4'b0100 || dmem_addr !== 32'h1000 || mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_issue: got rmask=%b addr=%h stall=%b, expected 0100 00001000 1",
               dmem_rmask, dmem_addr, mem_stall);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      @(negedge clk);
      n_tests++;
      if (dmem_rmask !== 4'b0000 || dmem_addr !== 32'h1000 || mem_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL lb_wait%0d: got rmask=%b addr=%h stall=%b, expected 0000 00001000 1",
                 k, dmem_rmask, dmem_addr, mem_stall);
      end
    end
    step();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h80FF_0000;
    @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_resp: got stall=%b err=%b, expected 0 0", mem_stall, mem_err);
    end
    step();
    dmem_resp  = 1'b0;
    ex_mem_reg = '0;
    step();
  endtask

  task automatic test_sh();
    step();
    ex_mem_reg = mk(1'b0, 1'b1, F3_H, WB_ALU, 1'b0, 32'h2002, 32'h0, 1'b0, 32'h1234, 5'd0);
    exp_q.push_back(ex(5'd0, 1'b0, 32'h0));
    @(negedge clk);
    n_tests++;
    if (dmem_wmask !== 4'b1100 || dmem_wdata !== 32'h1234_0000 || dmem_addr !== 32'h2000 ||
        dmem_rmask !== 4'b0000) begin
      n_fail++;
      $display("FAIL sh_issue: got wmask=%b wdata=%h addr=%h rmask=%b, expected 1100 12340000 00002000 0000",
               dmem_wmask, dmem_wdata, dmem_addr, dmem_rmask);
    end
    step();
    dmem_resp = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dmem_wmask !== 4'b0000 || dmem_wdata !== 32'h1234_0000 || dmem_addr !== 32'h2000 ||
        mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_resp: got wmask=%b wdata=%h addr=%h stall=%b, expected 0000 12340000 00002000 0",
               dmem_wmask, dmem_wdata, dmem_addr, mem_stall);
    end
    step();
    dmem_resp  = 1'b0;
    ex_mem_reg = '0;
    step();
  endtask

  task automatic test_rst_wait();
    step();
    ex_mem_reg = mk(1'b1, 1'b0, F3_W, WB_ALU, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0, 5'd9);
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dmem_rmask, dmem_wmask, mem_stall, mem_err, mem_wb_reg.valid_s} !== 11'b0) begin
      n_fail++;
      $display("FAIL rst_wait_outs: got rmask=%b wmask=%b stall=%b err=%b valid=%b, expected all 0",
               dmem_rmask, dmem_wmask, mem_stall, mem_err, mem_wb_reg.valid_s);
    end
    step();
    rst        = 1'b1;
    ex_mem_reg = '0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hCAFE_BABE;
    @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray_resp: got stall=%b err=%b, expected 0 0", mem_stall, mem_err);
    end
    step();
    dmem_resp = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_wb_reg.valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b, expected 0", mem_wb_reg.valid_s);
    end
  endtask

  task automatic test_timeout();
    step();
    ex_mem_reg = mk(1'b1, 1'b0, F3_W, WB_ALU, 1'b1, 32'h80, 32'h0, 1'b0, 32'h0, 5'd4);
    for (int k = 1; k <= 4; k++) begin
      step();
      @(negedge clk);
      n_tests++;
      if (mem_err !== (k == 4) || mem_stall !== (k != 4)) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: got err=%b stall=%b, expected err=%b stall=%b",
                 k, mem_err, mem_stall, (k == 4), (k != 4));
      end
    end
    step();
    ex_mem_reg = '0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    n_tests++;
    if (mem_err !== 1'b0 || mem_stall !== 1'b0 || mem_wb_reg.valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after: got err=%b stall=%b valid=%b, expected 0 0 0",
               mem_err, mem_stall, mem_wb_reg.valid_s);
    end
    step();
    dmem_resp = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    step();
    ex_mem_reg = mk(1'b1, 1'b0, F3_HU, WB_ALU, 1'b1, 32'h3000, 32'h0, 1'b0, 32'h0, 5'd6);
    exp_q.push_back(ex(5'd6, 1'b1, 32'h0000_8001));
    @(negedge clk);
    n_tests++;
    if (dmem_rmask !== 4'b0011 || dmem_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL lhu_issue: got rmask=%b addr=%h, expected 0011 00003000", dmem_rmask, dmem_addr);
    end
    step();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h0000_8001;
    @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu_resp_stall: got %b, expected 0", mem_stall);
    end
    step();
    dmem_resp  = 1'b0;
    ex_mem_reg = mk(1'b0, 1'b1, F3_W, WB_ALU, 1'b0, 32'h3004, 32'h0, 1'b0, 32'hDEAD_BEEF, 5'd0);
    exp_q.push_back(ex(5'd0, 1'b0, 32'h0));
    @(negedge clk);
    n_tests++;
    if (dmem_wmask !== 4'b1111 || dmem_wdata !== 32'hDEAD_BEEF || dmem_addr !== 32'h3004 ||
        mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_b2b_issue: got wmask=%b wdata=%h addr=%h stall=%b, expected 1111 deadbeef 00003004 1",
               dmem_wmask, dmem_wdata, dmem_addr, mem_stall);
    end
    step();
    dmem_resp = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b0 || dmem_wmask !== 4'b0000) begin
      n_fail++;
      $display("FAIL sw_b2b_resp: got stall=%b wmask=%b, expected 0 0000", mem_stall, dmem_wmask);
    end
    step();
    dmem_resp  = 1'b0;
    ex_mem_reg = '0;
    step();
  endtask

  initial begin
    rst        = 1'b0;
    ex_mem_reg = '0;
    dmem_rdata = '0;
    dmem_resp  = 1'b0;
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_rst_wait();
    test_timeout();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
